// File: rtl/scroll_pkg.sv
// -----------------------------------------------------------------------------
// scroll_pkg
// Shared types and constants for the platform scroll sequencer.
//   - scroll_state_e : sequencer FSM states
//   - PLAT_COUNT     : number of platforms in the external register file
//   - Y_WRAP         : screen height; platforms at or past it re-enter at top
//   - X_BASE         : left margin for re-entering platforms
//   - LFSR_SEED/TAPS : 16-bit LFSR start value and feedback taps (16,14,13,11)
// -----------------------------------------------------------------------------
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } scroll_state_e;

    localparam int PLAT_COUNT = 16;
    localparam int Y_WRAP     = 480;
    localparam int X_BASE     = 64;

    localparam int ADDR_W  = 4;
    localparam int COORD_W = 9;
    localparam int SHIFT_W = 8;
    localparam int SCORE_W = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 (1-based) map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Next state of a left-shifting Fibonacci LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/scroll_sequencer_if.sv
// -----------------------------------------------------------------------------
// scroll_sequencer_if
// Bundles the scroll request, the platform register-file port and the status
// outputs of the scroll sequencer.
//   refresh_en         : level scroll request
//   shift_amt[7:0]     : scroll distance (pixels)
//   plat_rx/ry[8:0]    : platform read data, valid one cycle after plat_addr
//   plat_addr[3:0]     : platform index
//   plat_we            : platform write strobe
//   plat_wx/wy[8:0]    : platform write data
//   trigger            : one-cycle scroll-complete pulse
//   busy               : high from accept through the trigger cycle
//   score[15:0]        : accumulated scroll distance
// master = sequencer side, slave = requester / register-file side.
// -----------------------------------------------------------------------------
interface scroll_sequencer_if;
    import scroll_pkg::*;

    logic                refresh_en;
    logic [SHIFT_W-1:0]  shift_amt;
    logic [COORD_W-1:0]  plat_rx;
    logic [COORD_W-1:0]  plat_ry;
    logic [ADDR_W-1:0]   plat_addr;
    logic                plat_we;
    logic [COORD_W-1:0]  plat_wx;
    logic [COORD_W-1:0]  plat_wy;
    logic                trigger;
    logic                busy;
    logic [SCORE_W-1:0]  score;

    modport master (
        input  refresh_en, shift_amt, plat_rx, plat_ry,
        output plat_addr, plat_we, plat_wx, plat_wy, trigger, busy, score
    );

    modport slave (
        output refresh_en, shift_amt, plat_rx, plat_ry,
        input  plat_addr, plat_we, plat_wx, plat_wy, trigger, busy, score
    );

endinterface

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, advances every clock.
//   Clk    : clock
//   Reset  : synchronous active-high reset, loads LFSR_SEED
//   q[15:0]: current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
    import scroll_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/scroll_sequencer.sv
// -----------------------------------------------------------------------------
// scroll_sequencer
// On a scroll request, walks all platforms of the external register file,
// moving each one down by the latched shift. Platforms that fall past the
// bottom of the screen wrap to the top at a pseudo-random X position.
// A single held request produces one scroll; the request must drop for at
// least one cycle before another is accepted.
//
// Ports:
//   Clk   : clock, all registers update on the rising edge
//   Reset : synchronous active-high reset; aborts any scroll in progress
//   bus   : scroll_sequencer_if.master (request, platform port, status)
//
// Build option:
//   SCROLL_SCORE_EN : when defined, score accumulates the shift of each
//                     completed scroll (saturating); otherwise score is 0.
// -----------------------------------------------------------------------------
module scroll_sequencer
    import scroll_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    scroll_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(PLAT_COUNT - 1);
    localparam logic [9:0]         Y_WRAP_W  = 10'(Y_WRAP);
    localparam logic [COORD_W-1:0] X_BASE_W  = COORD_W'(X_BASE);

    scroll_state_e       state_q;
    scroll_state_e       state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic                armed_q;
    logic                accept;
    logic [15:0]         lfsr_q;
    logic                lfsr_unused;

    logic [9:0]          sum_p0;
    logic                wrap_p0;
    logic [COORD_W-1:0]  x_new_p0;
    logic [COORD_W-1:0]  wx_p0;
    logic [COORD_W-1:0]  wy_p0;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .q     (lfsr_q)
    );

    // The top LFSR bit does not feed the X position.
    assign lfsr_unused = lfsr_q[15];

    assign accept = (state_q == IDLE) && bus.refresh_en && armed_q;

    // ---- control registers ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            shift_q <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;

            // Re-arm on any low cycle, even mid-scroll; disarm on accept.
            if (!bus.refresh_en) begin
                armed_q <= 1'b1;
            end else if (accept) begin
                armed_q <= 1'b0;
            end

            if (accept) begin
                shift_q <= bus.shift_amt;
                addr_q  <= '0;
            end else if ((state_q == WRITE) && (addr_q != LAST_ADDR)) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = READ;
            // READ holds the address for the register file's read latency.
            READ:    state_d = WRITE;
            WRITE:   state_d = (addr_q == LAST_ADDR) ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p0: combinational update of the platform read in WRITE ----
    always_comb begin
        sum_p0   = {1'b0, bus.plat_ry} + {2'b00, shift_q};
        wrap_p0  = (sum_p0 >= Y_WRAP_W);
        // 64 + [0..255] + [0..127] keeps the new X inside 64..446.
        x_new_p0 = X_BASE_W + {1'b0, lfsr_q[7:0]} + {2'b00, lfsr_q[14:8]};
        if (wrap_p0) begin
            wy_p0 = COORD_W'(sum_p0 - Y_WRAP_W);
            wx_p0 = x_new_p0;
        end else begin
            wy_p0 = sum_p0[COORD_W-1:0];
            wx_p0 = bus.plat_rx;
        end
    end

    // Write port and status decode straight from state, so a reset clears
    // them in the very next cycle and no write follows an abort.
    assign bus.plat_addr = addr_q;
    assign bus.plat_we   = (state_q == WRITE);
    assign bus.plat_wx   = (state_q == WRITE) ? wx_p0 : '0;
    assign bus.plat_wy   = (state_q == WRITE) ? wy_p0 : '0;
    assign bus.trigger   = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);

`ifdef SCROLL_SCORE_EN
    logic [SCORE_W-1:0] score_q;

    function automatic logic [SCORE_W-1:0] sat_add_score(
        input logic [SCORE_W-1:0] acc,
        input logic [SHIFT_W-1:0] inc
    );
        logic [SCORE_W:0] wide;
        wide = {1'b0, acc} + {{(SCORE_W + 1 - SHIFT_W){1'b0}}, inc};
        return wide[SCORE_W] ? {SCORE_W{1'b1}} : wide[SCORE_W-1:0];
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            score_q <= '0;
        end else if (state_q == DONE) begin
            score_q <= sat_add_score(score_q, shift_q);
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif

endmodule

// File: tb/tb_scroll_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scroll_sequencer
// Self-checking bench for scroll_sequencer. Models the external platform
// register file (one-cycle read latency), predicts every platform write into a
// scoreboard queue when a scroll is launched and compares it with the writes
// the sequencer actually issues.
// -----------------------------------------------------------------------------
module tb_scroll_sequencer;
    import scroll_pkg::*;

    typedef struct packed {
        logic       rnd;   // X is re-randomised: only its range is predictable
        logic [3:0] a;
        logic [8:0] x;
        logic [8:0] y;
    } wr_t;

    logic Clk = 1'b0;
    logic Reset;

    scroll_sequencer_if sif ();

    scroll_sequencer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (sif)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // platform register file model
    logic [8:0] mem_x [16];
    logic [8:0] mem_y [16];
    logic [8:0] init_x [16];
    logic [8:0] init_y [16];
    logic       load_req = 1'b0;

    always @(posedge Clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) begin
                mem_x[i] <= init_x[i];
                mem_y[i] <= init_y[i];
            end
        end else if (sif.plat_we === 1'b1) begin
            mem_x[sif.plat_addr] <= sif.plat_wx;
            mem_y[sif.plat_addr] <= sif.plat_wy;
        end
        sif.plat_rx <= mem_x[sif.plat_addr];
        sif.plat_ry <= mem_y[sif.plat_addr];
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    wr_t obs_q [$];
    wr_t exp_q [$];
    int  trig_cnt = 0;
    int  trig_cyc = 0;

    always @(negedge Clk) begin
        if (sif.plat_we === 1'b1)
            obs_q.push_back({1'b0, sif.plat_addr, sif.plat_wx, sif.plat_wy});
        if (sif.trigger === 1'b1) begin
            trig_cnt++;
            trig_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic wr_t model(input logic [3:0] a, input logic [8:0] x,
                                  input logic [8:0] y, input logic [7:0] s);
        int  sum;
        wr_t r;
        sum = int'(y) + int'(s);
        r.a = a;
        if (sum >= 480) begin
            r.rnd = 1'b1;
            r.x   = '0;
            r.y   = 9'(sum - 480);
        end else begin
            r.rnd = 1'b0;
            r.x   = x;
            r.y   = 9'(sum);
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic load_mem();
        tick();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Raises the request; acc returns the cycle number of the accept cycle.
    // shift_amt is scrambled right after accept to show it is ignored.
    task automatic start_scroll(input logic [7:0] amt, output int acc);
        sif.shift_amt  = amt;
        sif.refresh_en = 1'b1;
        acc = cyc;
        tick();
        sif.shift_amt = ~amt;
    endtask

    task automatic wait_trig(input int base, input int bound, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (trig_cnt != base) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_scroll(input logic [7:0] amt, output bit seen);
        int acc;
        int base;
        base = trig_cnt;
        start_scroll(amt, acc);
        wait_trig(base, 60, seen);
        sif.refresh_en = 1'b0;
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        Reset          = 1'b1;
        sif.refresh_en = 1'b0;
        sif.shift_amt  = '0;
        repeat (3) tick();
        n_checks++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", sif.busy); end
        n_checks++; if (sif.trigger !== 1'b0) begin n_fail++; $display("FAIL reset_trigger: got %b want 0", sif.trigger); end
        n_checks++; if (sif.plat_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", sif.plat_we); end
        n_checks++; if (sif.plat_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", sif.plat_addr); end
        n_checks++; if (sif.plat_wx !== 9'd0) begin n_fail++; $display("FAIL reset_wx: got %0d want 0", sif.plat_wx); end
        n_checks++; if (sif.plat_wy !== 9'd0) begin n_fail++; $display("FAIL reset_wy: got %0d want 0", sif.plat_wy); end
        n_checks++; if (sif.score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", sif.score); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int  acc;
        int  base;
        bit  seen;
        wr_t o;
        wr_t e;
        for (int i = 0; i < 16; i++) begin
            init_x[i] = 9'(i * 10 + 5);
            init_y[i] = 9'd100;
        end
        load_mem();
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(model(4'(i), init_x[i], init_y[i], 8'd20));
        base = trig_cnt;
        start_scroll(8'd20, acc);
        n_checks++; if (sif.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", sif.busy); end
        wait_trig(base, 60, seen);
        sif.refresh_en = 1'b0;
        tick();
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL basic_trigger: got none want pulse"); end
        n_checks++; if (trig_cyc - acc !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d want 33", trig_cyc - acc); end
        n_checks++; if (obs_q.size() !== 16) begin n_fail++; $display("FAIL basic_count: got %0d want 16", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.a !== e.a || o.x !== e.x || o.y !== e.y) begin
                n_fail++;
                $display("FAIL basic_write: got a=%0d x=%0d y=%0d want a=%0d x=%0d y=%0d", o.a, o.x, o.y, e.a, e.x, e.y);
            end
        end
    endtask

    task automatic test_wrap();
        int  acc;
        int  base;
        bit  seen;
        bit  rng_ok;
        wr_t o;
        wr_t e;
        for (int i = 0; i < 16; i++) begin
            init_x[i] = 9'(200 + i);
            init_y[i] = 9'(i * 20);
        end
        init_y[5] = 9'd470;
        load_mem();
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(model(4'(i), init_x[i], init_y[i], 8'd30));
        base = trig_cnt;
        start_scroll(8'd30, acc);
        wait_trig(base, 60, seen);
        sif.refresh_en = 1'b0;
        tick();
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL wrap_trigger: got none want pulse"); end
        n_checks++; if (obs_q.size() !== 16) begin n_fail++; $display("FAIL wrap_count: got %0d want 16", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            rng_ok = (o.x >= 9'd64) && (o.x <= 9'd446);
            n_checks++;
            if (o.a !== e.a || o.y !== e.y || (e.rnd ? (rng_ok !== 1'b1) : (o.x !== e.x))) begin
                n_fail++;
                $display("FAIL wrap_write: got a=%0d x=%0d y=%0d want a=%0d x=%0s y=%0d", o.a, o.x, o.y, e.a, e.rnd ? "64..446" : $sformatf("%0d", e.x), e.y);
            end
        end
    endtask

    task automatic test_hold();
        int acc;
        int base;
        bit seen;
        for (int i = 0; i < 16; i++) begin
            init_x[i] = 9'(i);
            init_y[i] = 9'(i);
        end
        load_mem();
        obs_q.delete();
        base = trig_cnt;
        sif.shift_amt  = 8'd10;
        sif.refresh_en = 1'b1;
        repeat (100) tick();
        n_checks++; if (trig_cnt - base !== 1) begin n_fail++; $display("FAIL hold_triggers: got %0d want 1", trig_cnt - base); end
        n_checks++; if (obs_q.size() !== 16) begin n_fail++; $display("FAIL hold_writes: got %0d want 16", obs_q.size()); end
        n_checks++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle_busy: got %b want 0", sif.busy); end
        sif.refresh_en = 1'b0;
        tick();
        base = trig_cnt;
        start_scroll(8'd10, acc);
        n_checks++; if (sif.busy !== 1'b1) begin n_fail++; $display("FAIL rearm_busy: got %b want 1", sif.busy); end
        wait_trig(base, 60, seen);
        sif.refresh_en = 1'b0;
        tick();
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rearm_trigger: got none want pulse"); end
        n_checks++; if (trig_cyc - acc !== 33) begin n_fail++; $display("FAIL rearm_latency: got %0d want 33", trig_cyc - acc); end
    endtask

    task automatic test_reset_mid();
        int  acc;
        int  base;
        wr_t e4;
        for (int i = 0; i < 16; i++) begin
            init_x[i] = 9'(300 + i);
            init_y[i] = 9'(50 + i);
        end
        load_mem();
        obs_q.delete();
        e4   = model(4'd4, init_x[4], init_y[4], 8'd40);
        base = trig_cnt;
        start_scroll(8'd40, acc);
        repeat (9) tick();
        Reset          = 1'b1;
        sif.refresh_en = 1'b0;
        tick();
        n_checks++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", sif.busy); end
        n_checks++; if (sif.plat_we !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %b want 0", sif.plat_we); end
        n_checks++; if (sif.trigger !== 1'b0) begin n_fail++; $display("FAIL abort_trigger: got %b want 0", sif.trigger); end
        Reset = 1'b0;
        repeat (40) tick();
        n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL abort_writes: got %0d want 5", obs_q.size()); end
        n_checks++; if (trig_cnt !== base) begin n_fail++; $display("FAIL abort_no_trigger: got %0d want 0", trig_cnt - base); end
        n_checks++; if (mem_y[4] !== e4.y) begin n_fail++; $display("FAIL abort_kept: got %0d want %0d", mem_y[4], e4.y); end
        n_checks++; if (mem_y[5] !== init_y[5]) begin n_fail++; $display("FAIL abort_untouched: got %0d want %0d", mem_y[5], init_y[5]); end
    endtask

    task automatic test_zero_shift();
        int  acc;
        int  base;
        bit  seen;
        wr_t o;
        wr_t e;
        for (int i = 0; i < 16; i++) begin
            init_x[i] = 9'($urandom_range(0, 511));
            init_y[i] = 9'($urandom_range(0, 479));
        end
        load_mem();
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(model(4'(i), init_x[i], init_y[i], 8'd0));
        base = trig_cnt;
        start_scroll(8'd0, acc);
        wait_trig(base, 60, seen);
        sif.refresh_en = 1'b0;
        tick();
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL zero_trigger: got none want pulse"); end
        n_checks++; if (trig_cyc - acc !== 33) begin n_fail++; $display("FAIL zero_latency: got %0d want 33", trig_cyc - acc); end
        n_checks++; if (obs_q.size() !== 16) begin n_fail++; $display("FAIL zero_count: got %0d want 16", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.a !== e.a || o.x !== e.x || o.y !== e.y) begin
                n_fail++;
                $display("FAIL zero_write: got a=%0d x=%0d y=%0d want a=%0d x=%0d y=%0d", o.a, o.x, o.y, e.a, e.x, e.y);
            end
        end
    endtask

    task automatic test_score();
        bit seen;
        int missed;
        int exp_score;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        missed = 0;
`ifdef SCROLL_SCORE_EN
        exp_score = 0;
        run_scroll(8'd200, seen); if (!seen) missed++; exp_score += 200;
        run_scroll(8'd255, seen); if (!seen) missed++; exp_score += 255;
        run_scroll(8'd100, seen); if (!seen) missed++; exp_score += 100;
        n_checks++; if (sif.score !== 16'(exp_score)) begin n_fail++; $display("FAIL score_sum: got %0d want %0d", sif.score, exp_score); end
        while (exp_score < 65535) begin
            run_scroll(8'd255, seen);
            if (!seen) missed++;
            exp_score = (exp_score + 255 > 65535) ? 65535 : exp_score + 255;
            obs_q.delete();
        end
        n_checks++; if (sif.score !== 16'hFFFF) begin n_fail++; $display("FAIL score_saturate: got %h want ffff", sif.score); end
`else
        exp_score = 0;
        run_scroll(8'd200, seen); if (!seen) missed++;
        n_checks++; if (sif.score !== 16'(exp_score)) begin n_fail++; $display("FAIL score_off_1: got %0d want 0", sif.score); end
        run_scroll(8'd255, seen); if (!seen) missed++;
        n_checks++; if (sif.score !== 16'(exp_score)) begin n_fail++; $display("FAIL score_off_2: got %0d want 0", sif.score); end
`endif
        n_checks++; if (missed !== 0) begin n_fail++; $display("FAIL score_scrolls: got %0d missing triggers want 0", missed); end
        obs_q.delete();
    endtask

    initial begin
        Reset          = 1'b1;
        sif.refresh_en = 1'b0;
        sif.shift_amt  = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_zero_shift();
        test_score();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
